config_word_assembler: RTL and testbench
========================================

CONFIG_WORD_ASSEMBLER -- requirements
Module: config_word_assembler

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, width of one configuration word fetched from memory.
REQ-002 SHALL have parameter WORDS_PER_CONFIG, default 5, number of fetched words per CGRA configuration word.
REQ-003 SHALL have parameter SIZE_WIDTH, default 16, width of the word-count size field.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1, one-cycle pulse that starts an assembly run.
REQ-007 SHALL have port clear_i, input, 1, synchronous abort back to IDLE.
REQ-008 SHALL have port data_config_size_i, input, SIZE_WIDTH, total fetched words in the run; sampled on an accepted start_i.
REQ-009 SHALL have port word_i, input, WORD_WIDTH, fetched word from the memory read engine.
REQ-010 SHALL have port word_valid_i, input, 1, word_i is valid.
REQ-011 SHALL have port word_ready_o, output, 1, block accepts word_i.
REQ-012 SHALL have port configuration_word_o, output, WORD_WIDTH*WORDS_PER_CONFIG, assembled word to the CGRA config_bitstream input.
REQ-013 SHALL have port config_valid_o, output, 1, configuration_word_o is valid.
REQ-014 SHALL have port config_ready_i, input, 1, CGRA consumes configuration_word_o.
REQ-015 SHALL have port busy_o, output, 1, high in COLLECT or EMIT.
REQ-016 SHALL have port done_o, output, 1, level-high in DONE; feeds the CSR done_config input.
REQ-017 SHALL have port words_accepted_o, output, SIZE_WIDTH, words accepted in the current run.

Function
REQ-018 SHALL implement the FSM states IDLE, COLLECT, EMIT and DONE.
REQ-019 SHALL accept start_i only in IDLE or DONE: it latches remaining = data_config_size_i, clears the buffer, slot index and words_accepted_o, then goes to COLLECT, or to DONE if the size is 0.
REQ-020 SHALL ignore start_i in COLLECT and EMIT.
REQ-021 SHALL drive word_ready_o = 1 only in COLLECT, so that a transfer is word_valid_i && word_ready_o.
REQ-022 SHALL write each transferred word into slot k at bits [k*WORD_WIDTH +: WORD_WIDTH], with slot 0 as the first word; it then increments k and words_accepted_o and decrements remaining.
REQ-023 SHALL go from COLLECT to EMIT on the cycle after the transfer that fills slot WORDS_PER_CONFIG-1 or brings remaining to 0; unfilled slots of a partial last group SHALL read as 0.
REQ-024 SHALL hold config_valid_o = 1 and configuration_word_o stable in EMIT until config_ready_i = 1.
REQ-025 SHALL, on the EMIT handshake, go to DONE if remaining == 0; otherwise it clears the buffer and k and returns to COLLECT.
REQ-026 SHALL give a latency of exactly 1 cycle from the group-completing transfer to config_valid_o high; no word is accepted during EMIT.
REQ-027 SHALL hold DONE, with done_o = 1, until an accepted start_i or clear_i.
REQ-028 SHALL, on clear_i in any state, go to IDLE next cycle with the buffer, k, remaining and words_accepted_o zeroed; clear_i has priority over start_i in the same cycle.
REQ-029 SHALL treat arithmetic as unsigned; remaining never underflows, because transfers are blocked at 0.

Reset
REQ-030 SHALL, while rst_ni = 0, enter IDLE with word_ready_o = 0, config_valid_o = 0, busy_o = 0, done_o = 0, configuration_word_o = 0 and words_accepted_o = 0.
REQ-031 SHALL, on reset mid-run, discard all partial data; no configuration word is emitted after reset release until a new start_i.

Structure
REQ-032 SHALL place the FSM state enum and the default WORD_WIDTH and WORDS_PER_CONFIG constants in a shared package, cgra_config_pkg.
REQ-033 SHALL be a single flat module with no sub-modules.

Verification
REQ-034 SHALL cover: size = 5, words 0x11..0x55, config_ready_i = 1 -> one config_valid_o pulse with word = {0x55,0x44,0x33,0x22,0x11}, then done_o = 1.
REQ-035 SHALL cover: size = 7 -> two emissions, the second = {0,0,0,0x77,0x66}, and words_accepted_o = 7.
REQ-036 SHALL cover: size = 0 -> done_o high on the cycle after start, with no config_valid_o.
REQ-037 SHALL cover: config_ready_i held low 10 cycles in EMIT -> word stable, word_ready_o = 0 for all 10 cycles.
REQ-038 SHALL cover: clear_i (or rst_ni low) after 3 words of a size-10 run -> IDLE and outputs zeroed; restart with size 5 yields only the new words.
REQ-039 SHALL cover: start_i pulsed during COLLECT -> ignored, and remaining and words_accepted_o are unchanged.

Source files
------------

// File: rtl/cgra_config_pkg.sv
// Shared definitions for the CGRA configuration word assembler.
package cgra_config_pkg;

    localparam int CWA_WORD_WIDTH       = 32;
    localparam int CWA_WORDS_PER_CONFIG = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DONE    = 2'd3
    } cwa_state_e;

endpackage : cgra_config_pkg

// File: rtl/config_word_assembler.sv
// Packs a stream of fetched memory words into wide CGRA configuration words
// and presents each one on a valid/ready handshake until the run is exhausted.
module config_word_assembler
    import cgra_config_pkg::*;
#(
    parameter int WORD_WIDTH       = CWA_WORD_WIDTH,
    parameter int WORDS_PER_CONFIG = CWA_WORDS_PER_CONFIG,
    parameter int SIZE_WIDTH       = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic                                 clear_i,
    input  logic [SIZE_WIDTH-1:0]                data_config_size_i,
    input  logic [WORD_WIDTH-1:0]                word_i,
    input  logic                                 word_valid_i,
    output logic                                 word_ready_o,
    output logic [WORD_WIDTH*WORDS_PER_CONFIG-1:0] configuration_word_o,
    output logic                                 config_valid_o,
    input  logic                                 config_ready_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [SIZE_WIDTH-1:0]                words_accepted_o
);

    localparam int SLOT_W = (WORDS_PER_CONFIG > 1) ? $clog2(WORDS_PER_CONFIG + 1) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORDS_PER_CONFIG - 1);

    cwa_state_e                            r_state;
    cwa_state_e                            w_state_next;
    logic [WORD_WIDTH*WORDS_PER_CONFIG-1:0] r_buffer;
    logic [SLOT_W-1:0]                     r_slot;
    logic [SIZE_WIDTH-1:0]                 r_remaining;
    logic [SIZE_WIDTH-1:0]                 r_words_accepted;

    logic w_collect_ready;
    logic w_transfer;
    logic w_group_end;
    logic w_start_accept;
    logic w_emit_refill;

    // Ready is withheld at remaining == 0 so the down-counter can never wrap.
    assign w_collect_ready = (r_state == ST_COLLECT) && (r_remaining != '0);
    assign w_transfer      = word_valid_i && w_collect_ready;
    assign w_group_end     = w_transfer &&
                             ((r_slot == LAST_SLOT) || (r_remaining == SIZE_WIDTH'(1)));
    assign w_emit_refill   = (r_state == ST_EMIT) && config_ready_i && (r_remaining != '0);

    assign word_ready_o         = w_collect_ready;
    assign configuration_word_o = r_buffer;
    assign words_accepted_o     = r_words_accepted;

    // NOTE: every signal written here gets a default first, otherwise an
    // unassigned path through the case infers a latch.
    always_comb begin
        w_state_next   = r_state;
        w_start_accept = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        config_valid_o = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_start_accept = start_i;
            end
            ST_COLLECT: begin
                busy_o = 1'b1;
                if (w_group_end) w_state_next = ST_EMIT;
            end
            ST_EMIT: begin
                busy_o         = 1'b1;
                config_valid_o = 1'b1;
                if (config_ready_i)
                    w_state_next = (r_remaining == '0) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                done_o         = 1'b1;
                w_start_accept = start_i;
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_start_accept)
            w_state_next = (data_config_size_i == '0) ? ST_DONE : ST_COLLECT;
        if (clear_i)
            w_state_next = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // NOTE: the assembly buffer is reset because it drives the output word,
    // which must read as zero after reset and after an abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buffer         <= '0;
            r_slot           <= '0;
            r_remaining      <= '0;
            r_words_accepted <= '0;
        end else if (clear_i) begin
            r_buffer         <= '0;
            r_slot           <= '0;
            r_remaining      <= '0;
            r_words_accepted <= '0;
        end else if (w_start_accept) begin
            r_buffer         <= '0;
            r_slot           <= '0;
            r_remaining      <= data_config_size_i;
            r_words_accepted <= '0;
        end else if (w_transfer) begin
            r_buffer[r_slot*WORD_WIDTH +: WORD_WIDTH] <= word_i;
            r_slot           <= r_slot + SLOT_W'(1);
            r_remaining      <= r_remaining - SIZE_WIDTH'(1);
            r_words_accepted <= r_words_accepted + SIZE_WIDTH'(1);
        end else if (w_emit_refill) begin
            // Next group starts from an empty buffer so a short tail reads as zero.
            r_buffer <= '0;
            r_slot   <= '0;
        end
    end

endmodule : config_word_assembler

// File: tb/tb_config_word_assembler.sv
// Directed self-checking bench for config_word_assembler.
module tb_config_word_assembler;

    localparam int W  = 32;
    localparam int N  = 5;
    localparam int SW = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic              clear_i = 1'b0;
    logic [SW-1:0]     data_config_size_i = '0;
    logic [W-1:0]      word_i = '0;
    logic              word_valid_i = 1'b0;
    logic              word_ready_o;
    logic [W*N-1:0]    configuration_word_o;
    logic              config_valid_o;
    logic              config_ready_i = 1'b1;
    logic              busy_o;
    logic              done_o;
    logic [SW-1:0]     words_accepted_o;

    int errors = 0;
    int checks = 0;

    localparam logic [W*N-1:0] EXP_G1  = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [W*N-1:0] EXP_G2  = {32'h0, 32'h0, 32'h0, 32'h77, 32'h66};
    localparam logic [W*N-1:0] EXP_A   = {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1};
    localparam logic [W*N-1:0] EXP_B   = {32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1};

    config_word_assembler #(
        .WORD_WIDTH(W), .WORDS_PER_CONFIG(N), .SIZE_WIDTH(SW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
        .data_config_size_i(data_config_size_i), .word_i(word_i),
        .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
        .configuration_word_o(configuration_word_o), .config_valid_o(config_valid_o),
        .config_ready_i(config_ready_i), .busy_o(busy_o), .done_o(done_o),
        .words_accepted_o(words_accepted_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [SW-1:0] size);
        start_i = 1'b1;
        data_config_size_i = size;
        step();
        start_i = 1'b0;
    endtask

    // Presents one word and holds it until the block takes it (bounded wait).
    task automatic put_word(input logic [W-1:0] w);
        int n = 0;
        word_valid_i = 1'b1;
        word_i = w;
        while (!word_ready_o && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL put_word_timeout: word_ready_o stayed %b, required 1", word_ready_o);
        end
        step();
        word_valid_i = 1'b0;
    endtask

    // Outputs expected in IDLE (after reset or clear).
    task automatic check_idle(input string tag);
        checks++;
        if ({word_ready_o, config_valid_o, busy_o, done_o} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_flags: ready/valid/busy/done=%b required 0000", tag,
                     {word_ready_o, config_valid_o, busy_o, done_o});
        end
        checks++;
        if (configuration_word_o !== '0) begin
            errors++;
            $display("FAIL %s_word: got %h required 0", tag, configuration_word_o);
        end
        checks++;
        if (words_accepted_o !== '0) begin
            errors++;
            $display("FAIL %s_accepted: got %0d required 0", tag, words_accepted_o);
        end
    endtask

    task automatic check_emit(input string tag, input logic [W*N-1:0] exp_word,
                              input logic [SW-1:0] exp_acc);
        checks++;
        if ({config_valid_o, word_ready_o, busy_o} !== 3'b101) begin
            errors++;
            $display("FAIL %s_emit_flags: valid/ready/busy=%b required 101", tag,
                     {config_valid_o, word_ready_o, busy_o});
        end
        checks++;
        if (configuration_word_o !== exp_word) begin
            errors++;
            $display("FAIL %s_emit_word: got %h required %h", tag, configuration_word_o, exp_word);
        end
        checks++;
        if (words_accepted_o !== exp_acc) begin
            errors++;
            $display("FAIL %s_emit_accepted: got %0d required %0d", tag, words_accepted_o, exp_acc);
        end
    endtask

    task automatic check_done(input string tag, input logic [SW-1:0] exp_acc);
        checks++;
        if ({done_o, busy_o, config_valid_o, word_ready_o} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_done_flags: done/busy/valid/ready=%b required 1000", tag,
                     {done_o, busy_o, config_valid_o, word_ready_o});
        end
        checks++;
        if (words_accepted_o !== exp_acc) begin
            errors++;
            $display("FAIL %s_done_accepted: got %0d required %0d", tag, words_accepted_o, exp_acc);
        end
    endtask

    task automatic test_reset();
        #2;
        check_idle("reset_asserted");
        step();
        rst_ni = 1'b1;
        step();
        check_idle("reset_released");
    endtask

    task automatic test_single_group();
        config_ready_i = 1'b1;
        do_start(SW'(5));
        checks++;
        if ({busy_o, word_ready_o, config_valid_o} !== 3'b110) begin
            errors++;
            $display("FAIL single_collect: busy/ready/valid=%b required 110",
                     {busy_o, word_ready_o, config_valid_o});
        end
        for (int i = 1; i <= 4; i++) put_word(W'(i * 'h11));
        checks++;
        if (config_valid_o !== 1'b0 || words_accepted_o !== SW'(4)) begin
            errors++;
            $display("FAIL single_partial: valid=%b accepted=%0d required 0 and 4",
                     config_valid_o, words_accepted_o);
        end
        put_word(32'h55);
        check_emit("single", EXP_G1, SW'(5));
        step();
        check_done("single", SW'(5));
    endtask

    task automatic test_two_groups();
        config_ready_i = 1'b1;
        do_start(SW'(7));
        checks++;
        if (words_accepted_o !== '0) begin
            errors++;
            $display("FAIL two_start_clears: accepted=%0d required 0", words_accepted_o);
        end
        for (int i = 1; i <= 5; i++) put_word(W'(i * 'h11));
        check_emit("two_g1", EXP_G1, SW'(5));
        step();
        checks++;
        if ({word_ready_o, config_valid_o} !== 2'b10 || configuration_word_o !== '0) begin
            errors++;
            $display("FAIL two_refill: ready/valid=%b word=%h required 10 and 0",
                     {word_ready_o, config_valid_o}, configuration_word_o);
        end
        put_word(32'h66);
        put_word(32'h77);
        check_emit("two_g2", EXP_G2, SW'(7));
        step();
        check_done("two", SW'(7));
    endtask

    task automatic test_zero_size();
        do_start(SW'(0));
        check_done("zero", SW'(0));
        checks++;
        if (configuration_word_o !== '0) begin
            errors++;
            $display("FAIL zero_word: got %h required 0", configuration_word_o);
        end
    endtask

    task automatic test_backpressure();
        config_ready_i = 1'b0;
        do_start(SW'(5));
        for (int i = 1; i <= 5; i++) put_word(W'(i * 'h11));
        word_valid_i = 1'b1;
        word_i = 32'hDEAD_BEEF;
        for (int c = 0; c < 10; c++) begin
            check_emit($sformatf("stall%0d", c), EXP_G1, SW'(5));
            step();
        end
        word_valid_i = 1'b0;
        config_ready_i = 1'b1;
        check_emit("stall_release", EXP_G1, SW'(5));
        step();
        check_done("stall", SW'(5));
    endtask

    task automatic test_start_ignored();
        config_ready_i = 1'b1;
        do_start(SW'(10));
        put_word(32'hA1);
        put_word(32'hA2);
        start_i = 1'b1;
        data_config_size_i = SW'(3);
        step();
        start_i = 1'b0;
        checks++;
        if ({busy_o, word_ready_o} !== 2'b11 || words_accepted_o !== SW'(2)) begin
            errors++;
            $display("FAIL ignored_start: busy/ready=%b accepted=%0d required 11 and 2",
                     {busy_o, word_ready_o}, words_accepted_o);
        end
        put_word(32'hA3);
        put_word(32'hA4);
        put_word(32'hA5);
        check_emit("ignored_g1", EXP_A, SW'(5));
        step();
        for (int i = 1; i <= 5; i++) put_word(W'('hB0 + i));
        check_emit("ignored_g2", EXP_B, SW'(10));
        step();
        check_done("ignored", SW'(10));
    endtask

    task automatic test_clear_restart();
        config_ready_i = 1'b1;
        do_start(SW'(10));
        put_word(32'hC1);
        put_word(32'hC2);
        put_word(32'hC3);
        checks++;
        if (words_accepted_o !== SW'(3)) begin
            errors++;
            $display("FAIL clear_pre: accepted=%0d required 3", words_accepted_o);
        end
        // Start in the same cycle as clear must lose.
        clear_i = 1'b1;
        start_i = 1'b1;
        data_config_size_i = SW'(5);
        step();
        clear_i = 1'b0;
        start_i = 1'b0;
        check_idle("clear");
        do_start(SW'(5));
        for (int i = 1; i <= 5; i++) put_word(W'(i * 'h11));
        check_emit("clear_restart", EXP_G1, SW'(5));
        step();
        check_done("clear_restart", SW'(5));
    endtask

    task automatic test_reset_midrun();
        config_ready_i = 1'b1;
        do_start(SW'(10));
        put_word(32'hE1);
        put_word(32'hE2);
        rst_ni = 1'b0;
        #2;
        check_idle("midrun_reset");
        step();
        rst_ni = 1'b1;
        word_valid_i = 1'b1;
        word_i = 32'hE3;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle($sformatf("post_reset%0d", c));
        end
        word_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_two_groups();
        test_zero_size();
        test_backpressure();
        test_start_ignored();
        test_clear_restart();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_config_word_assembler
